pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//   Parametrised, pipelined successor to the 8-bit combinational shifter. One log2-weighted shift
//   stage per shift-amount bit, each registered, with valid/ready flow control on both sides.
//   Adds carry-out and zero flags. Sits between the operand-select logic and the ALU writeback.
// PARAMETERS
//   WIDTH   32               data width; power of two, >= 4
//   SAW     $clog2(WIDTH)    shift-amount width (derived, do not override)
//   STAGES  SAW              pipeline depth = latency in cycles (derived)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   data_in    in   WIDTH  operand
//   shift_amt  in   SAW    shift distance 0..WIDTH-1
//   mode_sel   in   3      000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, others pass-through
//   out_valid  out  1      result beat valid
//   out_ready  in   1      consumer accepts result
//   data_out   out  WIDTH  shifted/rotated result
//   carry_out  out  1      see carry rules
//   zero_out   out  1      data_out == 0
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): all stage valid bits, out_valid, data_out, carry_out and zero_out
//     go to 0; in-flight beats are discarded, not completed. in_ready is 0 during reset and 1 in the
//     first cycle after rst_n returns high.
//   Transfer: a beat is taken when in_valid && in_ready and delivered when out_valid && out_ready.
//   Stage k (k = 0..STAGES-1) shifts by 2^k when amount bit k is set, else passes. Mode, remaining
//     amount bits and carry travel with the data.
//   Bubble-collapsing flow: stage k loads when its register is empty or stage k+1 loads in the same
//     cycle. The last stage advances when out_valid is 0 or out_ready is 1. in_ready = stage-0 load
//     condition. in_ready is combinational from out_ready through the stall chain (no register).
//   Latency: exactly STAGES cycles from acceptance to out_valid when unstalled.
//     Throughput: 1 beat/cycle.
//   Stall: while out_valid && !out_ready, data_out/carry_out/zero_out hold stable. Upstream
//     bubbles fill until all stages are full, then in_ready drops.
//   Arithmetic: LSL/LSR fill zeros. ASR fills with data_in[WIDTH-1].
//     ROR/ROL wrap bits modulo WIDTH. shift_amt = 0 returns data_in in every mode.
//   Carry rules:
//     LSL/LSR/ASR: the last bit shifted out is data_in[WIDTH-n] for LSL and data_in[n-1] for
//       LSR/ASR, where n = shift_amt. It is updated only in stages whose amount bit is set.
//     ROR: data_out[WIDTH-1]. ROL: data_out[0].
//     n = 0 or pass-through mode: 0.
//   Illegal mode codes (101..111): data_in passes through unchanged, carry 0. They are never dropped.
//   Simultaneous in/out transfer on a full pipe is legal and sustains 1 beat/cycle.
// STRUCTURE
//   Package barrel_shifter_pkg: shift_mode_e enum (LSL, LSR, ASR, ROR, ROL) and MODE_W = 3.
//   Sub-module barrel_shift_stage: #(WIDTH, DIST) one combinational 2^k step
//     (data, mode, enable -> data, carry_out).
//   Top: generate loop of STAGES × {barrel_shift_stage + pipeline register + valid bit}, plus
//     the ready chain.
// TESTING (WIDTH=8 unless noted; latency 3)
//   LSL 0x81 by 1 -> 0x02, carry 1, zero 0.  LSR 0x81 by 7 -> 0x01, carry 0.
//     ASR 0x80 by 3 -> 0xF0, carry 0.  LSL 0x80 by 1 -> 0x00, carry 1, zero 1.
//   ROR 0x01 by 1 -> 0x80, carry 1.  ROL 0x96 by 4 -> 0x69, carry 1.
//     Mode 3'b111 with 0x5A -> 0x5A, carry 0.
//   Back-to-back stream: 16 random beats with out_ready=1 -> one result per cycle, in order,
//     first result 3 cycles after the first acceptance, matched against a reference model.
//   Backpressure: hold out_ready=0 for 6 cycles with in_valid=1 -> in_ready drops after 3
//     accepts, outputs stable. Release -> no loss, no duplication.
//   Reset mid-flight: 2 beats in flight, pull rst_n low for 1 cycle -> out_valid=0 and data_out=0
//     next cycle; those beats never emerge.
//   WIDTH=32 sweep: every mode × shift_amt 0..31 on 0x8000_0001 and random data -> matches
//     the model, including carry and zero.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// barrel_shifter_pkg: shift mode encoding shared by the shifter top and its stages.
//   MODE_W       width of the mode field carried through the pipe
//   shift_mode_e LSL/LSR/ASR/ROR/ROL; codes 101..111 mean pass-through
package barrel_shifter_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        LSL = 3'b000,
        LSR = 3'b001,
        ASR = 3'b010,
        ROR = 3'b011,
        ROL = 3'b100
    } shift_mode_e;

endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: one combinational shift/rotate step by the fixed distance DIST.
//   data_i  operand entering the step
//   mode_i  shift mode (unknown codes pass through)
//   en_i    amount bit for this step; when low the operand passes untouched
//   data_o  operand after the step
//   carry_o last bit moved out (shift) or wrapped into the carry end (rotate)
module barrel_shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              en_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              carry_o
);

    localparam int INV = WIDTH - DIST;

    logic [WIDTH-1:0] lsl, lsr, asr;

    always_comb begin
        lsl = data_i << DIST;
        lsr = data_i >> DIST;
        asr = $unsigned($signed(data_i) >>> DIST);
        data_o = !en_i          ? data_i :
                 mode_i == LSL  ? lsl :
                 mode_i == LSR  ? lsr :
                 mode_i == ASR  ? asr :
                 mode_i == ROR  ? lsr | (data_i << INV) :
                 mode_i == ROL  ? lsl | (data_i >> INV) : data_i;
        // Bit INV leaves the top on left moves; bit DIST-1 leaves the bottom on right moves.
        carry_o = !en_i                          ? 1'b0 :
                  (mode_i == LSL || mode_i == ROL) ? data_i[INV] :
                  (mode_i == LSR || mode_i == ASR || mode_i == ROR) ? data_i[DIST-1] : 1'b0;
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2-staged registered shifter/rotator with valid/ready on both sides.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready is combinational from out_ready)
//   data_in, shift_amt   operand and distance 0..WIDTH-1
//   mode_sel             000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 ROL, others pass-through
//   out_valid/out_ready  output handshake
//   data_out, carry_out, zero_out  result, carry flag, result-is-zero flag
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter  int WIDTH  = 32,
    localparam int SAW    = $clog2(WIDTH),
    localparam int STAGES = SAW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [SAW-1:0]    shift_amt,
    input  logic [MODE_W-1:0] mode_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  data_out,
    output logic              carry_out,
    output logic              zero_out
);

    logic z_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [WIDTH-1:0]  src_data, d_d, d_q;
        logic [MODE_W-1:0] src_mode;
        // Only the amount bits not yet consumed travel; bit 0 drives this stage.
        logic [SAW-1-k:0]  src_amt;
        logic              src_valid, src_carry, c_st, c_d, v_q, c_q, ld;

        if (k == 0) begin : g_src
            assign src_data  = data_in;
            assign src_mode  = mode_sel;
            assign src_amt   = shift_amt;
            assign src_valid = in_valid;
            assign src_carry = 1'b0;
        end else begin : g_src
            assign src_data  = g_st[k-1].d_q;
            assign src_mode  = g_st[k-1].g_fwd.m_q;
            assign src_amt   = g_st[k-1].g_fwd.a_q;
            assign src_valid = g_st[k-1].v_q;
            assign src_carry = g_st[k-1].c_q;
        end

        // A stage loads when empty or when its successor is draining it this cycle.
        if (k == STAGES - 1) begin : g_ld
            assign ld = !v_q || out_ready;
        end else begin : g_ld
            assign ld = !v_q || g_st[k+1].ld;
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data_i  (src_data),
            .mode_i  (src_mode),
            .en_i    (src_amt[0]),
            .data_o  (d_d),
            .carry_o (c_st)
        );

        // Carry is only rewritten by stages that actually move bits.
        assign c_d = src_amt[0] ? c_st : src_carry;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
                c_q <= 1'b0;
            end else if (ld) begin
                v_q <= src_valid;
                d_q <= d_d;
                c_q <= c_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [MODE_W-1:0] m_q;
            logic [SAW-2-k:0]  a_q;
            always_ff @(posedge clk) begin
                if (ld) begin
                    m_q <= src_mode;
                    a_q <= src_amt[SAW-1-k:1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            z_q <= 1'b0;
        else if (g_st[STAGES-1].ld)
            z_q <= g_st[STAGES-1].d_d == '0;
    end

    assign in_ready  = rst_n && g_st[0].ld;
    assign out_valid = g_st[STAGES-1].v_q;
    assign data_out  = g_st[STAGES-1].d_q;
    assign carry_out = g_st[STAGES-1].c_q;
    assign zero_out  = z_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and random checks of the 8- and 32-bit shifter against a whole-word model.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic iv, ir, ov, ordy, co, zo;
    logic [7:0] di, dout;
    logic [2:0] sa, ms;
    logic iv32, ir32, ov32, co32, zo32;
    logic ordy32;
    logic [31:0] di32, do32;
    logic [4:0] sa32;
    logic [2:0] ms32;

    int errors = 0;
    int checks = 0;
    int got8 = 0;
    int got32 = 0;
    int base;

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        z;
    } res_t;

    res_t q8[$];
    res_t q32[$];
    res_t e8, e32;

    pipelined_barrel_shifter #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .data_in(di),
        .shift_amt(sa), .mode_sel(ms), .out_valid(ov), .out_ready(ordy),
        .data_out(dout), .carry_out(co), .zero_out(zo)
    );

    pipelined_barrel_shifter #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .data_in(di32),
        .shift_amt(sa32), .mode_sel(ms32), .out_valid(ov32), .out_ready(ordy32),
        .data_out(do32), .carry_out(co32), .zero_out(zo32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: shift the full operand by n in one go.
    function automatic res_t model(input logic [31:0] din, input int n, input logic [2:0] m, input int w);
        logic [31:0] mask, d, r;
        logic c;
        res_t o;
        mask = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
        d = din & mask;
        r = d;
        c = 1'b0;
        if (n != 0) begin
            case (m)
                3'd0: begin r = (d << n) & mask; c = d[w-n]; end
                3'd1: begin r = d >> n; c = d[n-1]; end
                3'd2: begin r = (d >> n) | (d[w-1] ? (mask & ~(mask >> n)) : 32'd0); c = d[n-1]; end
                3'd3: begin r = ((d >> n) | (d << (w - n))) & mask; c = r[w-1]; end
                3'd4: begin r = ((d << n) | (d >> (w - n))) & mask; c = r[0]; end
                default: ;
            endcase
        end
        o.d = r;
        o.c = c;
        o.z = (r == 32'd0);
        return o;
    endfunction

    // Scoreboard: transfers seen at the negedge complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            q32.delete();
        end else begin
            if (iv && ir) q8.push_back(model(32'(di), int'(sa), ms, 8));
            if (ov && ordy) begin
                if (q8.size() == 0) chk("u8_spurious_beat", 32'd1, 32'd0);
                else begin
                    e8 = q8.pop_front();
                    chk("u8_data", 32'(dout), e8.d);
                    chk("u8_carry", 32'(co), 32'(e8.c));
                    chk("u8_zero", 32'(zo), 32'(e8.z));
                    got8++;
                end
            end
            if (iv32 && ir32) q32.push_back(model(di32, int'(sa32), ms32, 32));
            if (ov32 && ordy32) begin
                if (q32.size() == 0) chk("u32_spurious_beat", 32'd1, 32'd0);
                else begin
                    e32 = q32.pop_front();
                    chk("u32_data", do32, e32.d);
                    chk("u32_carry", 32'(co32), 32'(e32.c));
                    chk("u32_zero", 32'(zo32), 32'(e32.z));
                    got32++;
                end
            end
        end
    end

    task automatic dir(input string tag, input logic [7:0] d, input logic [2:0] n, input logic [2:0] m,
                       input logic [7:0] ed, input logic ec, input logic ez);
        di = d;
        sa = n;
        ms = m;
        iv = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(ir), 32'd1);
        @(posedge clk);
        #1 iv = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk({tag, "_latency"}, 32'(ov), 32'(i == 3));
            if (i < 3) @(posedge clk);
        end
        chk({tag, "_data"}, 32'(dout), 32'(ed));
        chk({tag, "_carry"}, 32'(co), 32'(ec));
        chk({tag, "_zero"}, 32'(zo), 32'(ez));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        iv = 1'b0; ordy = 1'b1; di = '0; sa = '0; ms = '0;
        iv32 = 1'b0; ordy32 = 1'b1; di32 = '0; sa32 = '0; ms32 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(ir), 32'd0);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_data", 32'(dout), 32'd0);
        chk("rst_carry", 32'(co), 32'd0);
        chk("rst_zero", 32'(zo), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(ir), 32'd1);
        @(posedge clk);
        #1;

        dir("lsl_81_1", 8'h81, 3'd1, 3'b000, 8'h02, 1'b1, 1'b0);
        dir("lsr_81_7", 8'h81, 3'd7, 3'b001, 8'h01, 1'b0, 1'b0);
        dir("asr_80_3", 8'h80, 3'd3, 3'b010, 8'hF0, 1'b0, 1'b0);
        dir("lsl_80_1", 8'h80, 3'd1, 3'b000, 8'h00, 1'b1, 1'b1);
        dir("ror_01_1", 8'h01, 3'd1, 3'b011, 8'h80, 1'b1, 1'b0);
        dir("rol_96_4", 8'h96, 3'd4, 3'b100, 8'h69, 1'b1, 1'b0);
        dir("ill_5a_3", 8'h5A, 3'd3, 3'b111, 8'h5A, 1'b0, 1'b0);
        dir("asr_c3_0", 8'hC3, 3'd0, 3'b010, 8'hC3, 1'b0, 1'b0);

        base = got8;
        for (int i = 0; i < 16; i++) begin
            di = 8'($urandom);
            sa = 3'($urandom_range(0, 7));
            ms = 3'($urandom_range(0, 7));
            iv = 1'b1;
            @(negedge clk);
            chk("stream_in_ready", 32'(ir), 32'd1);
            chk("stream_out_valid", 32'(ov), 32'(i >= 3));
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_tail_valid", 32'(ov), 32'(i < 3));
            @(posedge clk);
            #1;
        end
        chk("stream_count", 32'(got8 - base), 32'd16);

        base = got8;
        ordy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            di = 8'($urandom);
            sa = 3'($urandom_range(0, 7));
            ms = 3'($urandom_range(0, 4));
            iv = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", 32'(ir), 32'(i < 3));
            if (i >= 3) begin
                chk("bp_out_valid", 32'(ov), 32'd1);
                chk("bp_hold_data", 32'(dout), q8[0].d);
                chk("bp_hold_carry", 32'(co), 32'(q8[0].c));
                chk("bp_hold_zero", 32'(zo), 32'(q8[0].z));
            end
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        ordy = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_delivered", 32'(got8 - base), 32'd3);
        chk("bp_drained", 32'(ov), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 2; i++) begin
            di = 8'($urandom);
            sa = 3'($urandom_range(1, 7));
            ms = 3'($urandom_range(0, 4));
            iv = 1'b1;
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(ir), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(ov), 32'd0);
        chk("midrst_data", 32'(dout), 32'd0);
        chk("midrst_in_ready_after", 32'(ir), 32'd1);
        base = got8;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_no_emerge", 32'(ov), 32'd0);
        end
        chk("midrst_count", 32'(got8 - base), 32'd0);
        @(posedge clk);
        #1;

        base = got32;
        for (int m = 0; m < 8; m++) begin
            for (int n = 0; n < 32; n++) begin
                for (int j = 0; j < 2; j++) begin
                    di32 = (j == 0) ? 32'h8000_0001 : $urandom;
                    sa32 = 5'(n);
                    ms32 = 3'(m);
                    iv32 = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        end
        iv32 = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sweep32_count", 32'(got32 - base), 32'd512);
        chk("sweep32_empty", 32'(q32.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
